// File: rtl/uart_receiver.sv
//-----------------------------------------------------------------------------
// uart_receiver
//   8N1 UART receiver with 16x oversampling, a one-byte holding register with
//   valid/ack handshake, framing-error pulse, sticky overrun flag and a
//   BREAK state that waits out a line held low after a bad stop bit.
//
// Parameters
//   CLK_FREQ      clock frequency in Hz
//   BAUD          serial bit rate in bit/s
//
// Ports
//   clock         single rising-edge clock
//   reset         asynchronous active-high reset
//   clock_en      global enable; when low every register holds
//   rx            serial input, idles high, asynchronous to clock
//   data_out      last accepted byte
//   data_valid    data_out holds an unconsumed byte
//   data_ack      consumer has taken data_out
//   framing_error one-cycle pulse when the stop bit is sampled low
//   overrun       sticky; a completed byte was dropped
//   busy          receiver FSM is not IDLE
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_receiver #(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = 9600
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       clock_en,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       data_valid,
   input  logic       data_ack,
   output logic       framing_error,
   output logic       overrun,
   output logic       busy
);

   // Clocks per oversample tick; clamped so the counter always has a width.
   localparam int DIV    = CLK_FREQ / (BAUD * 16);
   localparam int DIV_C  = (DIV < 2) ? 2 : DIV;
   localparam int CW     = $clog2(DIV_C);
   localparam logic [CW-1:0] DIV_LAST = CW'(DIV_C - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_t;

   //--------------------------------------------------------------------------
   // Input synchronizer; resets to the idle (high) line level so a reset
   // never looks like a start edge.
   //--------------------------------------------------------------------------
   logic rx_meta_q;
   logic rx_sync_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else if (clock_en) begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
      end
   end

   //--------------------------------------------------------------------------
   // Free-running oversample tick. It is deliberately not realigned to the
   // start edge, so sample points carry up to one tick of jitter.
   //--------------------------------------------------------------------------
   logic [CW-1:0] div_cnt_q;
   logic          tick;

   assign tick = clock_en && (div_cnt_q == DIV_LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         div_cnt_q <= '0;
      end else if (clock_en) begin
         if (div_cnt_q == DIV_LAST) div_cnt_q <= '0;
         else                       div_cnt_q <= div_cnt_q + 1'b1;
      end
   end

   //--------------------------------------------------------------------------
   // Receive FSM. deliver_q is a one-cycle strobe raised on a good stop bit;
   // the handshake block below consumes it in the following cycle.
   //--------------------------------------------------------------------------
   state_t     state_q;
   logic [3:0] tcnt_q;
   logic [2:0] bidx_q;
   logic [7:0] shift_q;
   logic       deliver_q;
   logic       ferr_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         tcnt_q    <= 4'd0;
         bidx_q    <= 3'd0;
         shift_q   <= 8'h00;
         deliver_q <= 1'b0;
         ferr_q    <= 1'b0;
      end else if (!clock_en) begin
         // Everything freezes, but a pending error pulse must not reappear
         // when the enable comes back.
         ferr_q <= 1'b0;
      end else begin
         deliver_q <= 1'b0;
         ferr_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!rx_sync_q) begin
                  state_q <= START;
                  tcnt_q  <= 4'd0;
               end
            end
            START: begin
               if (tick) begin
                  // 8th tick lands mid start bit; a high line here is a glitch.
                  if (tcnt_q == 4'd7) begin
                     if (!rx_sync_q) begin
                        state_q <= DATA;
                        tcnt_q  <= 4'd0;
                        bidx_q  <= 3'd0;
                     end else begin
                        state_q <= IDLE;
                     end
                  end else begin
                     tcnt_q <= tcnt_q + 4'd1;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  if (tcnt_q == 4'd15) begin
                     tcnt_q  <= 4'd0;
                     shift_q <= {rx_sync_q, shift_q[7:1]};   // LSB first
                     if (bidx_q == 3'd7) state_q <= STOP;
                     else                bidx_q  <= bidx_q + 3'd1;
                  end else begin
                     tcnt_q <= tcnt_q + 4'd1;
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  if (tcnt_q == 4'd15) begin
                     tcnt_q <= 4'd0;
                     if (rx_sync_q) begin
                        deliver_q <= 1'b1;
                        state_q   <= IDLE;
                     end else begin
                        ferr_q  <= 1'b1;
                        state_q <= BREAK;
                     end
                  end else begin
                     tcnt_q <= tcnt_q + 4'd1;
                  end
               end
            end
            BREAK: begin
               if (rx_sync_q) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   //--------------------------------------------------------------------------
   // Holding register and handshake. An ack arriving together with a
   // delivery frees the register just in time, so the new byte is loaded
   // rather than counted as an overrun.
   //--------------------------------------------------------------------------
   logic [7:0] data_out_q, data_out_d;
   logic       valid_q,    valid_d;
   logic       overrun_q,  overrun_d;
   logic       accept;

   always_comb begin
      data_out_d = data_out_q;
      valid_d    = valid_q;
      overrun_d  = overrun_q;
      accept     = valid_q & data_ack;
      if (deliver_q) begin
         if (!valid_q || data_ack) begin
            data_out_d = shift_q;
            valid_d    = 1'b1;
            if (accept) overrun_d = 1'b0;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (accept) begin
         valid_d   = 1'b0;
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data_out_q <= 8'h00;
         valid_q    <= 1'b0;
         overrun_q  <= 1'b0;
      end else if (clock_en) begin
         data_out_q <= data_out_d;
         valid_q    <= valid_d;
         overrun_q  <= overrun_d;
      end
   end

   assign data_out      = data_out_q;
   assign data_valid    = valid_q;
   assign overrun       = overrun_q;
   assign framing_error = ferr_q & clock_en;
   assign busy          = (state_q != IDLE);

endmodule
